// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the stack processor: opcodes, PC mux selects, stack ops,
// controller state and the bundle of per-instruction control strobes.
package stack_cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_JUMP  = 4'h2;
    localparam logic [3:0] OP_BZ    = 4'h3;
    localparam logic [3:0] OP_CALL  = 4'h4;
    localparam logic [3:0] OP_RET   = 4'h5;
    localparam logic [3:0] OP_PUSHI = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;

    localparam logic [2:0] PC_RSTACK = 3'd0;
    localparam logic [2:0] PC_JUMP   = 3'd1;
    localparam logic [2:0] PC_BRANCH = 3'd2;
    localparam logic [2:0] PC_SEQ    = 3'd4;

    localparam logic [1:0] RS_HOLD = 2'b00;
    localparam logic [1:0] RS_PUSH = 2'b01;
    localparam logic [1:0] RS_POP  = 2'b10;

    localparam logic [1:0] DS_HOLD = 2'b00;
    localparam logic [1:0] DS_PUSH = 2'b01;
    localparam logic [1:0] DS_POP  = 2'b10;
    localparam logic [1:0] DS_ALU  = 2'b11;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StHalt,
        StTrap
    } state_e;

    typedef struct packed {
        logic        pc_write;
        logic [2:0]  pc_control;
        logic [1:0]  rstack_op;
        logic [1:0]  dstack_op;
        logic [2:0]  alu_oper;
        logic [15:0] imm;
    } ctrl_t;

endpackage

// File: rtl/inst_decode.sv
// Combinational decode of the latched instruction into EXEC-cycle strobes,
// immediate and opcode/overflow fault flag (stack-depth faults handled by the caller).
module inst_decode
    import stack_cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    input  logic        zero_i,
    input  logic        overflow_i,
    output ctrl_t       ctrl_o,
    output logic        is_call_o,
    output logic        is_ret_o,
    output logic        is_halt_o,
    output logic        fault_o
);

    logic [3:0]  opcode;
    logic [11:0] field;
    logic        illegal;

    assign opcode = ir_i[15:12];
    assign field  = ir_i[11:0];

    always_comb begin
        ctrl_o    = '0;
        is_call_o = 1'b0;
        is_ret_o  = 1'b0;
        is_halt_o = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_NOP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_control = PC_SEQ;
            end
            OP_ALU: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_control = PC_SEQ;
                ctrl_o.dstack_op  = DS_ALU;
                ctrl_o.alu_oper   = ir_i[2:0];
            end
            OP_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_control = PC_JUMP;
                ctrl_o.imm        = {3'b000, field, 1'b0};
            end
            OP_BZ: begin
                // Condition is consumed from the data stack whether or not taken
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_control = zero_i ? PC_BRANCH : PC_SEQ;
                ctrl_o.dstack_op  = DS_POP;
                ctrl_o.imm        = {{3{field[11]}}, field, 1'b0};
            end
            OP_CALL: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_control = PC_JUMP;
                ctrl_o.rstack_op  = RS_PUSH;
                ctrl_o.imm        = {3'b000, field, 1'b0};
                is_call_o         = 1'b1;
            end
            OP_RET: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_control = PC_RSTACK;
                ctrl_o.rstack_op  = RS_POP;
                is_ret_o          = 1'b1;
            end
            OP_PUSHI: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_control = PC_SEQ;
                ctrl_o.dstack_op  = DS_PUSH;
                ctrl_o.imm        = {{4{field[11]}}, field};
            end
            OP_HALT: begin
                is_halt_o = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        fault_o = illegal || (overflow_i && ctrl_o.pc_write && (ctrl_o.pc_control == PC_SEQ));
    end

endmodule

// File: rtl/pc_control_fsm.sv
// Fetch/decode/execute sequencer for the PC path: latches the instruction, drives
// EXEC-cycle strobes, tracks return-stack depth and parks in HALT or TRAP.
module pc_control_fsm
    import stack_cpu_pkg::*;
#(
    parameter int unsigned RSTACK_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] inst,
    input  logic        Overflow,
    input  logic        Zero,
    output logic        PCWrite,
    output logic [2:0]  PCControl,
    output logic [1:0]  RStackOP,
    output logic [1:0]  DStackOP,
    output logic [2:0]  ALUOper,
    output logic [15:0] Imm,
    output logic        Halted,
    output logic        Trap
);

    localparam int unsigned DepthW = $clog2(RSTACK_DEPTH + 1);

    state_e            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DepthW-1:0] depth_q, depth_d;
    logic              halted_q, halted_d;
    logic              trap_q, trap_d;

    ctrl_t dec_ctrl;
    ctrl_t out_ctrl;
    logic  dec_call;
    logic  dec_ret;
    logic  dec_halt;
    logic  dec_fault;
    logic  fault;

    inst_decode u_inst_decode (
        .ir_i       (ir_q),
        .zero_i     (Zero),
        .overflow_i (Overflow),
        .ctrl_o     (dec_ctrl),
        .is_call_o  (dec_call),
        .is_ret_o   (dec_ret),
        .is_halt_o  (dec_halt),
        .fault_o    (dec_fault)
    );

    // Bounds are checked before the counter moves, so depth never wraps
    assign fault = dec_fault
                || (dec_call && (depth_q == DepthW'(RSTACK_DEPTH)))
                || (dec_ret && (depth_q == '0));

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        depth_d  = depth_q;
        halted_d = halted_q;
        trap_d   = trap_q;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                ir_d    = inst;
                state_d = StExec;
            end
            StExec: begin
                if (fault) begin
                    trap_d  = 1'b1;
                    state_d = StTrap;
                end else if (dec_halt) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else begin
                    if (dec_call) depth_d = depth_q + DepthW'(1);
                    if (dec_ret)  depth_d = depth_q - DepthW'(1);
                    state_d = StFetch;
                end
            end
            StHalt:  state_d = StHalt;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= StFetch;
            ir_q     <= '0;
            depth_q  <= '0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            depth_q  <= depth_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    // Reset forces every output low in the same cycle it is asserted
    always_comb begin
        out_ctrl = '0;
        if (!Reset && (state_q == StExec) && !fault) begin
            out_ctrl = dec_ctrl;
        end
    end

    assign PCWrite   = out_ctrl.pc_write;
    assign PCControl = out_ctrl.pc_control;
    assign RStackOP  = out_ctrl.rstack_op;
    assign DStackOP  = out_ctrl.dstack_op;
    assign ALUOper   = out_ctrl.alu_oper;
    assign Imm       = out_ctrl.imm;
    assign Halted    = halted_q && !Reset;
    assign Trap      = trap_q && !Reset;

endmodule

// File: tb/tb_pc_control_fsm.sv
// Directed plus random checks of the PC-path controller against an
// instruction-level reference model.
module tb_pc_control_fsm;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] inst = '0;
    logic        Overflow = 1'b0;
    logic        Zero = 1'b0;
    logic        PCWrite;
    logic [2:0]  PCControl;
    logic [1:0]  RStackOP;
    logic [1:0]  DStackOP;
    logic [2:0]  ALUOper;
    logic [15:0] Imm;
    logic        Halted;
    logic        Trap;

    int total = 0;
    int bad   = 0;

    int m_depth  = 0;
    bit m_halted = 0;
    bit m_trap   = 0;

    pc_control_fsm #(.RSTACK_DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .inst      (inst),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .PCWrite   (PCWrite),
        .PCControl (PCControl),
        .RStackOP  (RStackOP),
        .DStackOP  (DStackOP),
        .ALUOper   (ALUOper),
        .Imm       (Imm),
        .Halted    (Halted),
        .Trap      (Trap)
    );

    always #5 CLK = ~CLK;

    // Strobes expected in EXEC: {PCWrite, PCControl, RStackOP, DStackOP, ALUOper, Imm}
    function automatic logic [26:0] ref_exec(input logic [15:0] w, input bit z, input bit ov,
                                             input int depth, output bit fault,
                                             output bit halt, output int dd);
        int op, fld, sfld, pcc, rop, dop, alu, imm;
        bit pcw;
        op   = int'(w) / 4096;
        fld  = int'(w) % 4096;
        sfld = (fld >= 2048) ? fld - 4096 : fld;
        pcw = 1; pcc = 0; rop = 0; dop = 0; alu = 0; imm = 0;
        fault = 0; halt = 0; dd = 0;
        case (op)
            0: pcc = 4;
            1: begin pcc = 4; dop = 3; alu = int'(w) % 8; end
            2: begin pcc = 1; imm = fld * 2; end
            3: begin pcc = z ? 2 : 4; dop = 2; imm = sfld * 2; end
            4: begin pcc = 1; rop = 1; imm = fld * 2; dd = 1; fault = (depth == DEPTH); end
            5: begin pcc = 0; rop = 2; dd = -1; fault = (depth == 0); end
            6: begin pcc = 4; dop = 1; imm = sfld; end
            7: begin pcw = 0; halt = 1; end
            default: fault = 1;
        endcase
        if (pcw && pcc == 4 && ov) fault = 1;
        if (fault) begin
            halt = 0;
            dd = 0;
            return '0;
        end
        return {pcw, 3'(pcc), 2'(rop), 2'(dop), 3'(alu), 16'(imm)};
    endfunction

    task automatic cyc(input logic [15:0] i, input bit z, input bit ov, input bit rst,
                       input logic [28:0] exp, input string tag);
        logic [28:0] obs;
        @(posedge CLK);
        #1;
        inst = i; Zero = z; Overflow = ov; Reset = rst;
        @(negedge CLK);
        obs = {PCWrite, PCControl, RStackOP, DStackOP, ALUOper, Imm, Halted, Trap};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cyc(16'($urandom), 1'($urandom), 1'($urandom), 1'b1, '0, "reset");
        m_depth = 0; m_halted = 0; m_trap = 0;
    endtask

    // One instruction slot (3 cycles); inst is valid only in DECODE, junk elsewhere
    task automatic run_inst(input logic [15:0] w, input bit z, input bit ov, input string tag);
        logic [26:0] s;
        bit f, h;
        int dd;
        if (m_halted || m_trap) begin
            for (int k = 0; k < 3; k++)
                cyc(16'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                    {27'b0, m_halted, m_trap}, {tag, "_stuck"});
        end else begin
            cyc(16'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, {tag, "_fetch"});
            cyc(w, 1'($urandom), 1'($urandom), 1'b0, '0, {tag, "_decode"});
            s = ref_exec(w, z, ov, m_depth, f, h, dd);
            cyc(16'($urandom), z, ov, 1'b0, {s, 2'b00}, {tag, "_exec"});
            if (f) m_trap = 1;
            else if (h) m_halted = 1;
            else m_depth += dd;
        end
    endtask

    initial begin
        logic [15:0] w;
        int op;
        do_reset(2);
        for (int k = 0; k < 3; k++) run_inst(16'h0000, 1'($urandom), 1'b0, "nop");
        run_inst(16'h2010, 1'b0, 1'b0, "jump");
        run_inst(16'h3FFE, 1'b1, 1'b0, "bz_taken");
        run_inst(16'h3FFE, 1'b0, 1'b0, "bz_not_taken");
        run_inst(16'h6FFF, 1'b0, 1'b0, "pushi");
        run_inst(16'h1003, 1'b0, 1'b0, "alu");
        run_inst(16'h5000, 1'b0, 1'b0, "ret_pre");
        do_reset(1);
        for (int k = 0; k < DEPTH; k++) run_inst(16'h4008, 1'b0, 1'b0, "call");
        run_inst(16'h4008, 1'b0, 1'b0, "call_overflow");
        run_inst(16'h0000, 1'b0, 1'b0, "after_trap");
        do_reset(1);
        run_inst(16'h5000, 1'b0, 1'b0, "ret_empty");
        do_reset(1);
        run_inst(16'h0000, 1'b0, 1'b1, "nop_ovf");
        do_reset(1);
        run_inst(16'h4123, 1'b0, 1'b0, "call1");
        run_inst(16'h3000, 1'b1, 1'b1, "bz_taken_ovf");
        run_inst(16'h5000, 1'b0, 1'b0, "ret1");
        run_inst(16'h9ABC, 1'b0, 1'b0, "illegal");
        do_reset(1);
        run_inst(16'h7000, 1'b0, 1'b0, "halt");
        for (int k = 0; k < 7; k++) run_inst(16'h0000, 1'b0, 1'b0, "halted");
        do_reset(1);
        // Reset during DECODE
        cyc(16'h2010, 1'b0, 1'b0, 1'b0, '0, "mid_fetch");
        cyc(16'h2010, 1'b0, 1'b0, 1'b1, '0, "mid_decode_reset");
        m_depth = 0; m_halted = 0; m_trap = 0;
        run_inst(16'h2010, 1'b0, 1'b0, "resume_jump");
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 11) < 11) ? $urandom_range(0, 6) : $urandom_range(7, 15);
            w = {4'(op), 12'($urandom)};
            run_inst(w, 1'($urandom), ($urandom_range(0, 15) == 0), "rand");
            if (m_halted || m_trap) begin
                run_inst(16'h0000, 1'b0, 1'b0, "rand_stop");
                do_reset(1);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_control_fsm.md
# pc_control_fsm

Multi-cycle fetch/decode/execute controller for the stack processor's PC path. It consumes the 16-bit instruction word from the PC/instruction-memory stage and produces that stage's `PCWrite`, `PCControl` and `RStackOP` strobes, plus the data-stack, ALU and immediate controls. It also tracks return-stack depth and traps on depth or PC-increment faults.

## Interface
- `RSTACK_DEPTH`, 16: return-stack entries; legal range 2..256.
- `CLK`  in  1  clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `inst`  in  16  instruction word from instruction memory; valid one cycle after PC changes.
- `Overflow`  in  1  overflow from the PC+2 adder.
- `Zero`  in  1  data-stack top equals 0.
- `PCWrite`  out  1  PC register load strobe.
- `PCControl`  out  3  PC mux select: 0 = return-stack top, 1 = absolute jump (`Imm`), 2 = PC-relative branch, 4 = PC+2.
- `RStackOP`  out  2  return-stack operation: 00 = hold, 01 = push PC+2, 10 = pop.
- `DStackOP`  out  2  data-stack operation: 00 = hold, 01 = push `Imm`, 10 = pop, 11 = pop2-push ALU result.
- `ALUOper`  out  3  ALU operation, taken from `IR[2:0]`.
- `Imm`  out  16  immediate or target, formed from IR.
- `Halted`  out  1  sticky; set by HALT.
- `Trap`  out  1  sticky; set by fault.

## Operation
- Internal state: 16-bit IR, state register, return-stack depth counter with width `$clog2(RSTACK_DEPTH+1)`.
- Opcode is `IR[15:12]`; `IR[11:0]` is the field.
- States:
  - FETCH: all strobes 0. Next state is DECODE.
  - DECODE: IR <= `inst`. Next state is EXEC.
  - EXEC: strobes are driven per opcode. Next state is FETCH, HALT or TRAP.
  - HALT: absorbing.
  - TRAP: absorbing.
- Opcodes, as EXEC outputs. Unlisted fields are 0. Every non-faulting instruction drives `PCWrite=1` in EXEC.
  - 0x0 NOP: `PCControl=4`.
  - 0x1 ALU: `PCControl=4`, `DStackOP=11`, `ALUOper=IR[2:0]`.
  - 0x2 JUMP: `PCControl=1`, `Imm = zext(IR[11:0])<<1`.
  - 0x3 BZ: `Imm = sext(IR[11:0])<<1`. `PCControl=2` if `Zero`, else 4. `DStackOP=10` (pop condition).
  - 0x4 CALL: `PCControl=1`, `RStackOP=01`, `Imm` as for JUMP, depth+1.
  - 0x5 RET: `PCControl=0`, `RStackOP=10`, depth-1.
  - 0x6 PUSHI: `PCControl=4`, `DStackOP=01`, `Imm = sext(IR[11:0])`.
  - 0x7 HALT: `PCWrite=0`. Next state is HALT; `Halted` <= 1.
  - 0x8–0xF: illegal, which is a fault.
- Faults are evaluated in EXEC:
  - the faults are: illegal opcode; CALL with depth == `RSTACK_DEPTH`; RET with depth == 0; `Overflow` high while `PCControl` would be 4;
  - on a fault, all strobes are 0, including `PCWrite`, and depth is unchanged;
  - next state is TRAP and `Trap` <= 1;
  - the PC therefore still addresses the faulting instruction.
- Outputs are combinational from the registered state and IR only; `inst`, `Zero` and `Overflow` affect outputs only in EXEC. No glitch path from `inst` to the strobes.

## Timing
- 3 cycles per instruction: FETCH, DECODE, EXEC.
- The PC updates on the edge that ends EXEC. The new `inst` is valid after FETCH (1-cycle synchronous memory) and is latched by the edge ending DECODE.
- Reset has priority over everything. In any state, the next state is FETCH, IR = 0x0000, depth = 0, and `Halted` = `Trap` = 0.
- All outputs are 0 during Reset and in the first FETCH after it.
- The return stack shares `Reset`, so the depth counter and the stack clear together.
- Depth wrap is impossible: the bounds are checked before incrementing or decrementing.
- HALT and TRAP hold all strobes at 0 indefinitely; only Reset exits them.

## Structure
- Shared package `stack_cpu_pkg`:
  - opcode localparams (`OP_NOP` … `OP_HALT`);
  - `PCControl` codes (`PC_RSTACK=0`, `PC_JUMP=1`, `PC_BRANCH=2`, `PC_SEQ=4`);
  - `RStackOP` and `DStackOP` codes;
  - state encoding.
- One sub-module, `inst_decode`: purely combinational, taking IR, `Zero` and `Overflow` to give the per-opcode strobes, `Imm` and a fault flag. The FSM, IR and depth counter stay in `pc_control_fsm`.

## Test plan
- Reset then `inst`=0x0000 (NOP) repeated → `PCWrite` pulses once every 3 cycles with `PCControl`=4; `Trap`=`Halted`=0.
- `inst`=0x2010 (JUMP) → in EXEC, `PCControl`=1, `Imm`=0x0020, `PCWrite`=1.
- `inst`=0x3FFE (BZ): with `Zero`=1 → `PCControl`=2, `Imm`=0xFFFC, `DStackOP`=10; with `Zero`=0 → `PCControl`=4.
- 16 CALLs (0x4008) then a 17th → the first 16 assert `RStackOP`=01; the 17th gives `PCWrite`=0, `Trap`=1, state stuck. Reset; then RET (0x5000) at depth 0 → `Trap`=1.
- `inst`=0x6FFF (PUSHI) → `DStackOP`=01, `Imm`=0xFFFF. `inst`=0x1003 (ALU) → `DStackOP`=11, `ALUOper`=3. NOP with `Overflow`=1 in EXEC → `Trap`=1, no `PCWrite`.
- HALT (0x7000) → `Halted`=1 with no strobes for 20 cycles. Reset asserted mid-DECODE → next cycle is FETCH with outputs 0; normal sequencing resumes.
